fir_sample_writer: RTL and testbench
====================================

Name: fir_sample_writer

Overview:
- Output-side companion to the 8-tap moving-average FIR. The FIR consumes input samples on a one-cycle read strobe; this block is the writer end toward the audio codec DAC.
- Captures each new filtered 24-bit sample one cycle after the FIR shift strobe, when the FIR's combinational sum has settled.
- Buffers captured samples in a small FIFO.
- Drains the FIFO to the codec using a write / write_ready handshake.

Parameters:
DATA_W, 24, sample width (signed two's complement; passed through unmodified)
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = in reset, sampled on rising clk)
sample_valid  input  1  same strobe that advances the FIR shift register (FIR read)
sample_in  input  DATA_W  FIR data_out
write_ready  input  1  codec DAC can accept a sample this cycle
write  output  1  one-cycle write pulse to codec
writedata  output  DATA_W  sample presented with write
count  output  CNT_W  FIFO occupancy
overflow  output  1  sticky: a captured sample was dropped

Behaviour:
- Reset (reset==0 at a rising edge):
  - write=0, writedata=0, count=0, overflow=0.
  - FIFO pointers cleared; the delayed capture strobe is cleared; FSM goes to IDLE.
  - Mid-operation reset discards all buffered and pending samples. A write pulse in flight is deasserted in the cycle after the reset edge.
- Capture:
  - cap_q is a 1-cycle delayed copy of sample_valid.
  - When cap_q==1 at edge k+1 (sample_valid high at edge k), sample_in is pushed.
  - Back-to-back sample_valid pushes every cycle.
- Full:
  - A push while count==DEPTH with no pop at the same edge drops the sample and sets overflow. FIFO contents are unchanged.
  - A push and a pop at the same edge while full are both performed; count is unchanged and overflow is not set.
- Empty: the FSM never issues write when count==0. No underrun condition exists.
- Drain FSM, states IDLE, ISSUE, HOLDOFF:
  - IDLE: if count!=0 and write_ready==1 at an edge, go to ISSUE and register writedata<=head.
  - ISSUE: write=1 for exactly this cycle; head is popped at the exiting edge; then go to HOLDOFF. write_ready is not re-checked in ISSUE.
  - HOLDOFF: write=0 for one cycle so the codec can update write_ready; then go to IDLE.
  - Result: maximum drain rate is 1 sample per 3 cycles, which is far above the audio rate.
- writedata holds its last value outside ISSUE.
- Latency from sample_valid (edge k) to write high, with an empty FIFO and write_ready=1: write is high in the cycle after edge k+2.
- count updates at every push/pop edge and is registered.
- Simultaneous push and pop when not full: count unchanged, ordering preserved (FIFO order).
- Pointers are DEPTH-modulo and wrap naturally. count is authoritative for full/empty.
- overflow is cleared only by reset.

Decomposition:
- Shared package fir_pkg: DATA_W constant, sample_t typedef (logic signed [DATA_W-1:0]), and the writer state enum {IDLE, ISSUE, HOLDOFF}.
- One sub-module: sample_fifo (DEPTH-entry register FIFO). It has push/pop/din/dout/count ports, uses synchronous active-low reset, and pop takes priority only as described above.
- The FSM and capture logic stay in fir_sample_writer.

Test Plan:
1. Reset held 0 for 2 cycles with sample_valid pulsing -> write=0, count=0, overflow=0 throughout, and no write after reset is released until a new sample arrives.
2. write_ready=1; sample_valid pulse with sample_in=20 presented the cycle after -> count=1 after edge k+1; write=1 with writedata=20 in the cycle after edge k+2; count returns to 0.
3. write_ready=0; push 40, 10, 20, 60 -> count=4. Raise write_ready -> writes occur in order 40, 10, 20, 60, spaced 3 cycles apart; count ends at 0.
4. write_ready=0; push 5 samples (1..5) -> count=4, overflow=1, sample 5 dropped. The drain yields 1, 2, 3, 4 only.
5. FIFO full with the FSM in ISSUE on the same edge as a capture of 100 -> count stays 4, overflow stays 0, and 100 is written last.
6. Push 2 samples, then drive reset=0 during ISSUE -> write is low the next cycle and count=0. After release, no stale write occurs; a new sample of -8 (0xFFFFF8) is written intact.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types for the moving-average FIR output path: sample width,
// sample type and the DAC writer state encoding.
package fir_pkg;
  localparam int DATA_W = 24;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } writer_state_e;
endpackage

// File: rtl/fir_sample_writer_if.sv
// Signal bundle between the FIR output side and the codec DAC writer.
// master = FIR/codec environment, slave = fir_sample_writer.
interface fir_sample_writer_if #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  import fir_pkg::*;

  // write/write_ready: the writer issues write only after it has seen
  // write_ready high while idle; the codec takes writedata on the single
  // cycle write is high, and write_ready is not consulted during that cycle.
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              write_ready;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  writer_state_e     dbg_state;

  modport master (
    output sample_valid, sample_in, write_ready,
    input  write, writedata, count, overflow, dbg_state
  );

  modport slave (
    input  sample_valid, sample_in, write_ready,
    output write, writedata, count, overflow, dbg_state
  );
endinterface

// File: rtl/sample_fifo.sv
// DEPTH-entry register FIFO. A push into a full FIFO is dropped unless a
// pop happens on the same edge; drop reports the lost sample.
module sample_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              drop
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;

  always_comb begin
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || pop);
    drop     = push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fir_sample_writer.sv
// Captures each settled FIR output one cycle after the shift strobe,
// buffers it and drains it to the codec DAC at most once per three cycles.
module fir_sample_writer #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  fir_sample_writer_if.slave bus
);
  import fir_pkg::*;

  logic              cap_q, cap_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  writer_state_e     state_q, state_d;
  logic              pop;
  logic              drop;
  logic              write;
  logic              start;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap_q),
    .pop   (pop),
    .din   (bus.sample_in),
    .dout  (head),
    .count (count),
    .drop  (drop)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cap_q       <= 1'b0;
      overflow_q  <= 1'b0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      overflow_q  <= overflow_d;
      writedata_q <= writedata_d;
    end
  end

  always_comb begin
    start   = (state_q == IDLE) && (count != '0) && bus.write_ready;
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   state_d = HOLDOFF;
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The FIR sum settles one cycle after its shift strobe, hence cap_q.
  always_comb begin
    write       = (state_q == ISSUE);
    pop         = (state_q == ISSUE);
    cap_d       = bus.sample_valid;
    overflow_d  = overflow_q | drop;
    writedata_d = start ? head : writedata_q;
  end

  assign bus.write     = write;
  assign bus.writedata = writedata_q;
  assign bus.count     = count;
  assign bus.overflow  = overflow_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fir_sample_writer.sv
// Directed bench for fir_sample_writer: vector table for the basic
// latency/drain timing, hand-written sequences for reset, overflow and full-FIFO cases.
module tb_fir_sample_writer;
  import fir_pkg::*;

  localparam int W = 24;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  fir_sample_writer_if #(.DATA_W(W), .DEPTH(4)) bus ();

  fir_sample_writer #(.DATA_W(W), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sv;
    logic [W-1:0] sin;
    logic         wr;
    logic         exp_write;
    logic [W-1:0] exp_wd;
    logic [2:0]   exp_cnt;
    logic         exp_ovf;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];

  function automatic void add(logic sv, logic [W-1:0] sin, logic wr, logic ew,
                              logic [W-1:0] ewd, logic [2:0] ec, logic eo);
    vec_t v;
    v.sv = sv; v.sin = sin; v.wr = wr; v.exp_write = ew;
    v.exp_wd = ewd; v.exp_cnt = ec; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  // Apply inputs, take one rising edge, settle 1 ns before any check.
  task automatic cyc(input logic sv, input logic [W-1:0] sin, input logic wr);
    bus.sample_valid = sv;
    bus.sample_in    = sin;
    bus.write_ready  = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic ew, input logic [2:0] ec, input logic eo);
    chk({name, "_write"}, 32'(bus.write), 32'(ew));
    chk({name, "_count"}, 32'(bus.count), 32'(ec));
    chk({name, "_ovf"}, 32'(bus.overflow), 32'(eo));
  endtask

  // Drains exp_q in order; each write must appear within a bounded window.
  task automatic drain_check(input string name);
    while (exp_q.size() != 0) begin
      logic [W-1:0] e;
      bit seen;
      e = exp_q.pop_front();
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
        cyc(1'b0, '0, 1'b1);
        if (bus.write) seen = 1'b1;
      end
      if (!seen) chk({name, "_timeout"}, 32'(0), 32'(1));
      else       chk({name, "_data"}, 32'(bus.writedata), 32'(e));
    end
  endtask

  task automatic no_write_for(input string name, input int n);
    int writes;
    writes = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, '0, 1'b1);
      if (bus.write) writes++;
    end
    chk(name, 32'(writes), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    sample_t neg8;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.write_ready  = 1'b0;

    // Test 1: reset held with sample_valid pulsing, then quiet release.
    reset = 1'b0;
    cyc(1'b1, 24'd5, 1'b1);
    chk_outs("rst0", 1'b0, 3'd0, 1'b0);
    chk("rst0_wd", 32'(bus.writedata), 32'(0));
    chk("rst0_state", 32'(bus.dbg_state), 32'(IDLE));
    cyc(1'b1, 24'd6, 1'b1);
    chk_outs("rst1", 1'b0, 3'd0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 24'd7, 1'b1);
    chk_outs("rel0", 1'b0, 3'd0, 1'b0);
    no_write_for("rel_no_write", 4);
    chk("rel_count", 32'(bus.count), 32'(0));

    // Test 2: single sample latency.
    add(1'b1, 24'd0,  1'b1, 1'b0, 24'd0,  3'd0, 1'b0);
    add(1'b0, 24'd20, 1'b1, 1'b0, 24'd0,  3'd1, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b1, 24'd20, 3'd1, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd20, 3'd0, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd20, 3'd0, 1'b0);
    // Test 3: fill with write_ready low, then drain every third cycle.
    add(1'b1, 24'd0,  1'b0, 1'b0, 24'd20, 3'd0, 1'b0);
    add(1'b1, 24'd40, 1'b0, 1'b0, 24'd20, 3'd1, 1'b0);
    add(1'b1, 24'd10, 1'b0, 1'b0, 24'd20, 3'd2, 1'b0);
    add(1'b1, 24'd20, 1'b0, 1'b0, 24'd20, 3'd3, 1'b0);
    add(1'b0, 24'd60, 1'b0, 1'b0, 24'd20, 3'd4, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b1, 24'd40, 3'd4, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd40, 3'd3, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd40, 3'd3, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b1, 24'd10, 3'd3, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd10, 3'd2, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd10, 3'd2, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b1, 24'd20, 3'd2, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd20, 3'd1, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd20, 3'd1, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b1, 24'd60, 3'd1, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd60, 3'd0, 1'b0);
    add(1'b0, 24'd0,  1'b1, 1'b0, 24'd60, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].sv, vecs[i].sin, vecs[i].wr);
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_write, vecs[i].exp_cnt, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_wd", i), 32'(bus.writedata), 32'(vecs[i].exp_wd));
    end

    // Test 4: five pushes into four entries; sample 5 dropped.
    do_reset();
    cyc(1'b1, 24'd0, 1'b0);
    cyc(1'b1, 24'd1, 1'b0);
    cyc(1'b1, 24'd2, 1'b0);
    cyc(1'b1, 24'd3, 1'b0);
    cyc(1'b1, 24'd4, 1'b0);
    chk_outs("ovf_pre", 1'b0, 3'd4, 1'b0);
    cyc(1'b0, 24'd5, 1'b0);
    chk_outs("ovf_set", 1'b0, 3'd4, 1'b1);
    exp_q = '{24'd1, 24'd2, 24'd3, 24'd4};
    drain_check("ovf_drain");
    no_write_for("ovf_no_extra", 6);
    chk_outs("ovf_end", 1'b0, 3'd0, 1'b1);

    // Test 5: capture of 100 on the pop edge of a full FIFO.
    do_reset();
    chk("full_ovf_cleared", 32'(bus.overflow), 32'(0));
    cyc(1'b1, 24'd0,  1'b0);
    cyc(1'b1, 24'd11, 1'b0);
    cyc(1'b1, 24'd12, 1'b0);
    cyc(1'b1, 24'd13, 1'b0);
    cyc(1'b0, 24'd14, 1'b0);
    chk_outs("full_pre", 1'b0, 3'd4, 1'b0);
    cyc(1'b1, 24'd0, 1'b1);
    chk_outs("full_issue", 1'b1, 3'd4, 1'b0);
    chk("full_issue_wd", 32'(bus.writedata), 32'(11));
    cyc(1'b0, 24'd100, 1'b0);
    chk_outs("full_pushpop", 1'b0, 3'd4, 1'b0);
    chk("full_holdoff", 32'(bus.dbg_state), 32'(HOLDOFF));
    exp_q = '{24'd12, 24'd13, 24'd14, 24'd100};
    drain_check("full_drain");
    no_write_for("full_no_extra", 4);
    chk_outs("full_end", 1'b0, 3'd0, 1'b0);

    // Test 6: reset during ISSUE, then a clean negative sample.
    do_reset();
    cyc(1'b1, 24'd0, 1'b0);
    cyc(1'b1, 24'd7, 1'b0);
    cyc(1'b0, 24'd9, 1'b0);
    chk_outs("mid_pre", 1'b0, 3'd2, 1'b0);
    cyc(1'b0, 24'd0, 1'b1);
    chk_outs("mid_issue", 1'b1, 3'd2, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 24'd0, 1'b1);
    chk_outs("mid_rst", 1'b0, 3'd0, 1'b0);
    chk("mid_rst_wd", 32'(bus.writedata), 32'(0));
    reset = 1'b1;
    no_write_for("mid_no_stale", 6);
    neg8 = -24'sd8;
    cyc(1'b1, 24'd0, 1'b1);
    cyc(1'b0, neg8, 1'b1);
    chk("mid_neg_count", 32'(bus.count), 32'(1));
    exp_q = '{24'hFFFFF8};
    drain_check("mid_neg");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
